// File: rtl/serial_parity_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker_pkg
// Description : Shared state encodings and helpers for the serial parity
//               receive checker and its matching TX generator.
//               Contents:
//                 state_t      - 2-bit frame state
//                 c_ST_IDLE    - 2'd0, waiting for start
//                 c_ST_DATA    - 2'd1, collecting data bits
//                 c_ST_PARITY  - 2'd2, waiting for the parity bit
//                 c_ST_DONE    - 2'd3, one-cycle completion state
//                 is_busy()    - true for the states that hold a frame
// Revision    : 1.0 - initial release
// ============================================================================
package serial_parity_checker_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_DATA   = 2'd1;
    localparam state_t c_ST_PARITY = 2'd2;
    localparam state_t c_ST_DONE   = 2'd3;

    function automatic logic is_busy(input state_t s);
        return (s == c_ST_DATA) || (s == c_ST_PARITY);
    endfunction

endpackage : serial_parity_checker_pkg
`default_nettype wire

// File: rtl/serial_parity_checker_acc.sv
`default_nettype none
// ============================================================================
// Module      : parity_bit_acc
// Description : Running XOR of the accepted data bits of one frame.
//               Ports:
//                 clk - clock, rising edge
//                 rst - asynchronous active-high reset
//                 clr - synchronous clear (frame open), wins over en
//                 en  - fold d into the accumulator this cycle
//                 d   - incoming data bit
//                 acc - accumulated XOR of the data bits so far
// Revision    : 1.0 - initial release
// ============================================================================
module parity_bit_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule : parity_bit_acc
`default_nettype wire

// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker
// Description : Receives DATA_W data bits (LSB first) followed by one parity
//               bit, deserialises the word and flags a parity mismatch.
//               Configuration macro PARITY_ODD_EN: defined selects odd
//               parity, undefined selects even parity.
//               Ports:
//                 clk       - clock, rising edge
//                 rst       - asynchronous active-high reset
//                 start     - 1-cycle pulse opening a frame (IDLE only)
//                 bit_in    - serial bit, sampled when bit_valid=1
//                 bit_valid - bit_in qualifier; low stalls the frame
//                 busy      - high while collecting data or parity
//                 done      - 1-cycle pulse, data_out/err valid
//                 err       - parity mismatch, meaningful with done only
//                 data_out  - deserialised word, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] data_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PARITY_ODD_EN
    localparam logic c_ODD = 1'b1;
`else
    localparam logic c_ODD = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              w_acc;
    logic              w_open;
    logic              w_data_take;
    logic              w_par_take;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    // bit_valid only matters in DATA/PARITY; in IDLE and the start cycle it
    // is ignored because these qualifiers look at the current state.
    assign w_open      = (r_state == c_ST_IDLE)   && start;
    assign w_data_take = (r_state == c_ST_DATA)   && bit_valid;
    assign w_par_take  = (r_state == c_ST_PARITY) && bit_valid;

    parity_bit_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (w_open),
        .en  (w_data_take),
        .d   (bit_in),
        .acc (w_acc)
    );

    // State register; busy/done are flopped from the next-state decode so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_state_nxt = c_ST_DATA;
            c_ST_DATA:   if (bit_valid && (r_cnt == c_LAST_BIT)) w_state_nxt = c_ST_PARITY;
            c_ST_PARITY: if (bit_valid) w_state_nxt = c_ST_DONE;
            c_ST_DONE:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = is_busy(w_state_nxt);
        w_done_nxt = (w_state_nxt == c_ST_DONE);
    end

    // Datapath: counter and shift register advance only on accepted data
    // bits, so a low bit_valid holds everything indefinitely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_shreg  <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            if (w_open) begin
                r_cnt <= '0;
            end else if (w_data_take) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shreg <= {bit_in, r_shreg[DATA_W-1:1]};
            end

            // err is live only during the done cycle, then drops back to 0.
            if (w_par_take) begin
                data_out <= r_shreg;
                err      <= w_acc ^ bit_in ^ c_ODD;
            end else if (r_state == c_ST_DONE) begin
                err <= 1'b0;
            end
        end
    end

endmodule : serial_parity_checker
`default_nettype wire
